// File: rtl/echo_pkg.sv
// Shared types and helpers for the multi-channel echo datapath:
// FSM state encoding, width-generic saturation and lane slicing.
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    MIX,
    WRITE
  } state_t;

  localparam int SAT_W = 64;

  // Clamp a wide signed value into the range of a width-bit signed number.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                  input int width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (width - 1)) - 1;
    lo = -(SAT_W'(1) <<< (width - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  function automatic int lane_lo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port delay-line RAM: one write port, one synchronous read port,
// no reset so it maps onto block RAM.
module delay_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/multichannel_echo.sv
// Multi-channel echo/delay: channels are processed one after another through a
// shared delay RAM and multiplier, three cycles (READ, MIX, WRITE) per channel.
module multichannel_echo
  import echo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0]          delay_len,
  input  logic [GAIN_WIDTH-1:0]          wet_gain,
  input  logic                           feedback_en,
  input  logic                           bypass,
  output logic                           out_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           busy,
  output logic                           overrun
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RAM_AW = CH_W + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;
  localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(CHANNELS - 1);

  state_t                          state_reg;
  logic [CH_W-1:0]                 ch_reg;
  logic [ADDR_WIDTH-1:0]           wp_reg;
  logic [ADDR_WIDTH-1:0]           fill_reg;
  logic [ADDR_WIDTH-1:0]           delay_reg;
  logic [GAIN_WIDTH-1:0]           gain_reg;
  logic                            feedback_reg;
  logic                            bypass_reg;
  logic [CHANNELS*DATA_WIDTH-1:0]  frame_reg;
  logic [CHANNELS*DATA_WIDTH-1:0]  out_data_reg;
  logic                            out_valid_reg;
  logic                            busy_reg;
  logic                            overrun_reg;
  logic signed [DATA_WIDTH-1:0]    mix_reg;

  logic                            ram_we;
  logic                            ram_re;
  logic [RAM_AW-1:0]               ram_waddr;
  logic [RAM_AW-1:0]               ram_raddr;
  logic [DATA_WIDTH-1:0]           ram_wdata;
  logic [DATA_WIDTH-1:0]           ram_rdata;

  logic                            echo_on;
  logic signed [DATA_WIDTH-1:0]    dry;
  logic signed [DATA_WIDTH-1:0]    delayed;
  logic signed [DATA_WIDTH-1:0]    wet;
  logic signed [DATA_WIDTH+GAIN_WIDTH:0] prod;
  logic signed [DATA_WIDTH:0]      sum;
  logic signed [SAT_W-1:0]         sum_sat;

  // Samples older than what has been written since reset are never trusted.
  assign echo_on = (delay_reg != '0) && (delay_reg <= fill_reg);
  assign dry     = frame_reg[lane_lo(int'(ch_reg), DATA_WIDTH) +: DATA_WIDTH];
  assign delayed = echo_on ? signed'(ram_rdata) : '0;
  assign prod    = delayed * signed'({1'b0, gain_reg});
  assign wet     = DATA_WIDTH'(prod >>> GAIN_WIDTH);
  assign sum     = (DATA_WIDTH+1)'(dry) + (DATA_WIDTH+1)'(wet);
  assign sum_sat = sat(SAT_W'(sum), DATA_WIDTH);

  assign ram_re    = (state_reg == READ);
  assign ram_raddr = {ch_reg, wp_reg - delay_reg};
  assign ram_we    = (state_reg == WRITE);
  assign ram_waddr = {ch_reg, wp_reg};
  assign ram_wdata = (feedback_reg && !bypass_reg) ? mix_reg : dry;

  delay_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(RAM_AW),
    .DEPTH     (CHANNELS << ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ch_reg        <= '0;
      wp_reg        <= '0;
      fill_reg      <= '0;
      delay_reg     <= '0;
      gain_reg      <= '0;
      feedback_reg  <= 1'b0;
      bypass_reg    <= 1'b0;
      frame_reg     <= '0;
      mix_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      overrun_reg   <= in_valid && busy_reg;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            frame_reg    <= in_data;
            delay_reg    <= delay_len;
            gain_reg     <= wet_gain;
            feedback_reg <= feedback_en;
            bypass_reg   <= bypass;
            ch_reg       <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= READ;
          end
        end
        READ: state_reg <= MIX;
        MIX: begin
          mix_reg   <= DATA_WIDTH'(sum_sat);
          state_reg <= WRITE;
        end
        WRITE: begin
          out_data_reg[lane_lo(int'(ch_reg), DATA_WIDTH) +: DATA_WIDTH] <= bypass_reg ? dry : mix_reg;
          if (ch_reg == LAST_CH) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
            wp_reg        <= wp_reg + 1'b1;
            if (fill_reg != FILL_MAX) fill_reg <= fill_reg + 1'b1;
          end else begin
            ch_reg    <= ch_reg + 1'b1;
            state_reg <= READ;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign busy      = busy_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_multichannel_echo.sv
// Directed bench for multichannel_echo (2 channels, 16-deep delay line):
// table of hand-computed frames plus handshake, reset and wrap sequences.
module tb_multichannel_echo;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int AW = 4;
  localparam int GW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [CH*DW-1:0]  in_data;
  logic [AW-1:0]     delay_len;
  logic [GW-1:0]     wet_gain;
  logic              feedback_en;
  logic              bypass;
  logic              out_valid;
  logic [CH*DW-1:0]  out_data;
  logic              busy;
  logic              overrun;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit                   do_rst;
    logic signed [DW-1:0] d0;
    logic signed [DW-1:0] d1;
    logic [AW-1:0]        dly;
    logic [GW-1:0]        gain;
    bit                   fb;
    bit                   byp;
    logic signed [DW-1:0] e0;
    logic signed [DW-1:0] e1;
  } vec_t;

  vec_t tbl[$];

  multichannel_echo #(
    .DATA_WIDTH(DW),
    .CHANNELS  (CH),
    .ADDR_WIDTH(AW),
    .GAIN_WIDTH(GW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .delay_len  (delay_len),
    .wet_gain   (wet_gain),
    .feedback_en(feedback_en),
    .bypass     (bypass),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic void add(input bit r, input int d0, input int d1, input int dly,
                              input int g, input bit fb, input bit byp,
                              input int e0, input int e1);
    vec_t v;
    v.do_rst = r;
    v.d0     = 16'(d0);
    v.d1     = 16'(d1);
    v.dly    = 4'(dly);
    v.gain   = 8'(g);
    v.fb     = fb;
    v.byp    = byp;
    v.e0     = 16'(e0);
    v.e1     = 16'(e1);
    tbl.push_back(v);
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Launch one frame, scramble the inputs after acceptance, wait for out_valid.
  task automatic run_frame(input logic signed [DW-1:0] d0, input logic signed [DW-1:0] d1,
                           input logic [AW-1:0] dly, input logic [GW-1:0] g,
                           input bit fb, input bit byp,
                           output logic signed [DW-1:0] o0, output logic signed [DW-1:0] o1,
                           output int lat);
    @(negedge clk);
    in_data     = {d1, d0};
    delay_len   = dly;
    wet_gain    = g;
    feedback_en = fb;
    bypass      = byp;
    in_valid    = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid    = 1'b0;
      in_data     = ~{d1, d0};
      delay_len   = ~dly;
      wet_gain    = ~g;
      feedback_en = ~fb;
      bypass      = ~byp;
      lat++;
    end while (!out_valid && lat < 20);
    o0 = out_data[DW-1:0];
    o1 = out_data[2*DW-1:DW];
  endtask

  initial begin
    logic signed [DW-1:0] o0, o1, r0, r1;
    int lat;
    int st [2][70];
    int ov_cnt, ov_at, of_cnt, of_at, seen;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; delay_len = '0;
    wet_gain = '0; feedback_en = 1'b0; bypass = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;

    // delay 0 means echo off: output is the dry input; also seeds RAM with junk
    for (int n = 0; n < 16; n++) begin
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      run_frame(r0, r1, 4'd0, 8'($urandom), 1'($urandom), 1'b0, o0, o1, lat);
      $display("junk frame %0d: in=(%0d,%0d) out=(%0d,%0d) lat=%0d", n, r0, r1, o0, o1, lat);
      check($sformatf("off%0d_ch0", n), o0, r0);
      check($sformatf("off%0d_ch1", n), o1, r1);
      if (n == 0) check("off_latency", lat, 7);
    end

    // fill guard: first 10 frames dry, frame 10 picks up frame 0
    for (int n = 0; n <= 10; n++)
      add(n == 0, n*100 + 7, -(n*50 + 3), 10, 128, 0, 0,
          (n < 10) ? n*100 + 7 : 1010, (n < 10) ? -(n*50 + 3) : -505);
    // impulse, no feedback
    for (int n = 0; n <= 8; n++)
      add(n == 0, (n == 0) ? 1000 : 0, 0, 4, 128, 0, 0,
          (n == 0) ? 1000 : (n == 4) ? 500 : 0, 0);
    // impulse, feedback (crosses pointer wrap at frame 16)
    for (int n = 0; n <= 16; n++)
      add(n == 0, (n == 0) ? 1000 : 0, 0, 4, 128, 1, 0,
          (n == 0) ? 1000 : (n == 4) ? 500 : (n == 8) ? 250 :
          (n == 12) ? 125 : (n == 16) ? 62 : 0, 0);
    // saturation and rounding toward -inf
    add(1, 30000, -30000, 1, 255, 0, 0, 30000, -30000);
    add(0, 30000, -30000, 1, 255, 0, 0, 32767, -32768);
    add(0, -1, -1, 1, 255, 0, 0, 29881, -29884);
    add(0, 0, 0, 1, 255, 0, 0, -1, -1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) do_reset();
      run_frame(tbl[i].d0, tbl[i].d1, tbl[i].dly, tbl[i].gain, tbl[i].fb, tbl[i].byp, o0, o1, lat);
      $display("row %0d: in=(%0d,%0d) out=(%0d,%0d) want=(%0d,%0d) lat=%0d",
               i, tbl[i].d0, tbl[i].d1, o0, o1, tbl[i].e0, tbl[i].e1, lat);
      check($sformatf("row%0d_ch0", i), o0, tbl[i].e0);
      check($sformatf("row%0d_ch1", i), o1, tbl[i].e1);
      check($sformatf("row%0d_lat", i), lat, 7);
    end

    // wrap-around with delay 15, then bypass with feedback, then echo resumes
    do_reset();
    for (int n = 0; n < 70; n++) begin
      bit byp, fb;
      int d [2];
      int e [2];
      byp  = (n >= 40 && n < 48);
      fb   = (n >= 40);
      d[0] = (n*1231) % 40000 - 20000;
      d[1] = 15000 - (n*777) % 30000;
      for (int c = 0; c < 2; c++) begin
        int del, s;
        del = (n >= 15) ? st[c][n-15] : 0;
        s   = clamp16(d[c] + ((del * 200) >>> 8));
        e[c] = byp ? d[c] : s;
        st[c][n] = (fb && !byp) ? s : d[c];
      end
      run_frame(16'(d[0]), 16'(d[1]), 4'd15, 8'd200, fb, byp, o0, o1, lat);
      $display("wrap frame %0d: in=(%0d,%0d) out=(%0d,%0d) want=(%0d,%0d)",
               n, d[0], d[1], o0, o1, e[0], e[1]);
      check($sformatf("wrap%0d_ch0", n), o0, e[0]);
      check($sformatf("wrap%0d_ch1", n), o1, e[1]);
    end

    // handshake: second strobe two edges after accept is dropped
    do_reset();
    @(negedge clk);
    in_data = {16'sd222, 16'sd111}; delay_len = '0; wet_gain = '0;
    feedback_en = 1'b0; bypass = 1'b0; in_valid = 1'b1;
    ov_cnt = 0; ov_at = -1; of_cnt = 0; of_at = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin ov_cnt++; ov_at = i; end
      if (overrun) begin of_cnt++; of_at = i; end
      if (i <= 6) check($sformatf("hs_busy%0d", i), busy, (i <= 5) ? 1 : 0);
      in_valid = (i == 1);
      in_data  = {16'sd999, 16'sd888};
    end
    $display("handshake: out_valid x%0d at %0d, overrun x%0d at %0d, out=%h",
             ov_cnt, ov_at, of_cnt, of_at, out_data);
    check("hs_ov_count", ov_cnt, 1);
    check("hs_ov_at", ov_at, 6);
    check("hs_of_count", of_cnt, 1);
    check("hs_of_at", of_at, 2);
    check("hs_data", out_data, {16'sd222, 16'sd111});

    // reset three edges into a frame: abort, everything back to zero
    @(negedge clk);
    in_data = {16'sd4321, 16'sd1234}; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("mid-frame reset: out=%h valid=%0d busy=%0d overrun=%0d", out_data, out_valid, busy, overrun);
    check("mr_out_data", out_data, 0);
    check("mr_out_valid", out_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_overrun", overrun, 0);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mr_no_valid", seen, 0);

    // fill restarted: first frame after reset is dry, second echoes it
    run_frame(16'sd500, -16'sd500, 4'd1, 8'd255, 1'b0, 1'b0, o0, o1, lat);
    $display("post-reset frame 0: out=(%0d,%0d)", o0, o1);
    check("pr0_ch0", o0, 500);
    check("pr0_ch1", o1, -500);
    run_frame(16'sd0, 16'sd0, 4'd1, 8'd255, 1'b0, 1'b0, o0, o1, lat);
    $display("post-reset frame 1: out=(%0d,%0d)", o0, o1);
    check("pr1_ch0", o0, 498);
    check("pr1_ch1", o1, -499);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multichannel_echo.md
# multichannel_echo

Parametrised multi-channel echo/delay effect for the audio codec datapath. Takes one packed frame of signed PCM samples per `in_valid` strobe, mixes each channel with a runtime-programmable delayed copy scaled by a fractional gain, and optionally feeds the mix back into the delay line for repeating echoes. Runs on the single system clock. Channels are processed time-multiplexed through one shared delay RAM and one multiplier.

## Interface
- `DATA_WIDTH`, 16, sample width (signed two's complement)
- `CHANNELS`, 2, number of audio channels per frame
- `ADDR_WIDTH`, 12, delay-line depth per channel = 2^ADDR_WIDTH samples
- `GAIN_WIDTH`, 8, unsigned wet gain, value g means g/2^GAIN_WIDTH
- `clk` in 1 system clock; all logic on rising edge
- `rst` in 1 reset, synchronous, active-high
- `in_valid` in 1 frame strobe; accepted only when `busy`=0
- `in_data` in CHANNELS*DATA_WIDTH packed frame, channel 0 in LSBs
- `delay_len` in ADDR_WIDTH delay in frames; 0 = echo off
- `wet_gain` in GAIN_WIDTH delayed-path gain
- `feedback_en` in 1 1: write mixed output into delay line; 0: write dry input
- `bypass` in 1 1: output = dry input (delay line still written with dry)
- `out_valid` out 1 one-cycle pulse, frame on `out_data` is new
- `out_data` out CHANNELS*DATA_WIDTH processed frame, same packing; held between pulses
- `busy` out 1 frame in progress
- `overrun` out 1 one-cycle pulse: `in_valid` seen while `busy`, frame dropped

## Operation
- Accept edge: `in_data`, `delay_len`, `wet_gain`, `feedback_en`, `bypass` captured into registers; later changes do not affect the frame in flight.
- FSM: IDLE -> (READ -> MIX -> WRITE) per channel, ch 0..CHANNELS-1 -> IDLE. WRITE of the last channel returns to IDLE and advances the frame write pointer `wp`.
- RAM: CHANNELS*2^ADDR_WIDTH words, address {ch, ptr}; synchronous read, 1-cycle latency; no reset of contents.
- READ: issue read at {ch, wp - delay_len} mod 2^ADDR_WIDTH.
- MIX: `wet = (delayed * wet_gain) >>> GAIN_WIDTH` (arithmetic, rounds toward -inf); `sum = dry + wet` at DATA_WIDTH+1 bits; saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- `delayed` forced to 0 when `delay_len`=0 or `delay_len` > `fill`; `fill` counts frames written since reset, saturating at 2^ADDR_WIDTH-1. Uninitialised RAM never reaches the output.
- WRITE: store at {ch, wp}: saturated sum if `feedback_en`&&!`bypass`, else dry. `out_data` lane ch updated with sum, or dry if `bypass`.
- Wrap-around: `wp` and read address wrap modulo 2^ADDR_WIDTH; max delay 2^ADDR_WIDTH-1.
- Overrun: `in_valid` while `busy`=1 -> `overrun` pulse next cycle, frame discarded, no effect on state.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `overrun`=0, `wp`=0, `fill`=0, FSM IDLE.
- Frame accepted at edge k -> `busy`=1 after k; `out_valid` pulses for the cycle after edge k+3*CHANNELS (7 cycles total latency for CHANNELS=2), `busy` falls on the same edge.
- Earliest next accept: edge k+3*CHANNELS+1; sustained throughput 1 frame per 3*CHANNELS+1 cycles.
- `out_data` lanes update during processing but are only valid when `out_valid`=1.
- `rst` mid-frame: abort immediately, no `out_valid`, `wp`/`fill` reset; RAM contents ignored via `fill`=0.

## Structure
- Shared package `echo_pkg`: FSM state enum (IDLE, READ, MIX, WRITE), `sat` function parameterised by width, lane index/slicing helpers.
- Sub-module `delay_ram`: simple dual-port sync-read RAM (DATA_WIDTH x CHANNELS*2^ADDR_WIDTH), no reset, inferable to block RAM.
- Top holds FSM, channel counter, `wp`, `fill`, multiplier and saturating adder.

## Test plan
- Impulse, CHANNELS=2, ADDR_WIDTH=4, delay_len=4, gain=128, feedback off: ch0 frame 0 = 1000, then zeros -> outputs 1000, 0,0,0, 500, then 0; ch1 all 0.
- Feedback on, same stimulus -> 1000 @0, 500 @4, 250 @8, 125 @12, 62 @16.
- Saturation: dry 30000, prior sample 30000, gain 255, delay 1 -> wet 29882, out 32767; negated -> -32768. Gain 255 on -1 -> wet -1.
- Fill guard: after reset, delay_len=10, random RAM preload -> first 10 frames equal dry exactly; frame 10 includes echo.
- Wrap and bypass: delay_len=15, ADDR_WIDTH=4, 40 frames ramp -> out[n]=sat(in[n]+in[n-15]*g/256) across pointer wrap; bypass=1 -> out=in, echo resumes from stored dry history when cleared.
- Handshake/reset: in_valid at k and k+2 -> one out_valid at k+7, overrun at k+3; rst at k+3 of a new frame -> no out_valid, all outputs 0.
